// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the gpio_irq block: register offsets and byte-lane helper.
package gpio_irq_pkg;

  // Word offsets of the eight registers on wb_adr_i[4:2].
  typedef enum logic [2:0] {
    GPIO_REG_DAT = 3'd0,
    GPIO_REG_DIR = 3'd1,
    GPIO_REG_SET = 3'd2,
    GPIO_REG_CLR = 3'd3,
    GPIO_REG_TGL = 3'd4,
    GPIO_REG_RIE = 3'd5,
    GPIO_REG_FIE = 3'd6,
    GPIO_REG_IP  = 3'd7
  } gpio_reg_e;

  // Expand the four byte-lane selects into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_irq_sync.sv
// Per-pin input synchroniser with one history flop for edge detection.
module gpio_irq_sync #(
  parameter int N           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic [N-1:0] pad,
  output logic [N-1:0] s,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] hist_q;

  // Shift the raw pad value through the synchroniser chain, then into the history flop.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= pad;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~hist_q;
  assign fall = ~s & hist_q;

endmodule

// File: rtl/iobuf.sv
// Behavioural model of the IOBuf pad cell: tri-state driver plus input tap.
module IOBuf (
  input  logic bit_i,
  input  logic oe_i,
  output logic bit_o,
  inout  wire  pad_io
);

  assign pad_io = oe_i ? bit_i : 1'bz;
  assign bit_o  = pad_io;

endmodule

// File: rtl/gpio_irq.sv
// Wishbone GPIO with atomic SET/CLR/TGL, edge-detect pending bits and a level IRQ.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int N           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic [4:2]   wb_adr_i,
  input  logic [31:0]  wb_dat_i,
  output logic [31:0]  wb_dat_o,
  input  logic         wb_we_i,
  input  logic [3:0]   wb_sel_i,
  input  logic         wb_stb_i,
  output logic         wb_ack_o,
  inout  wire  [N-1:0] gpio_io,
  output logic         irq_o
);

  logic [N-1:0] pad_in, s, rise, fall;
  logic [N-1:0] out_q, dir_q, rie_q, fie_q, ip_q;
  logic [N-1:0] wmask, wdat, ip_clr, rd_val;
  logic [31:0]  lane_full;
  logic         access, wr;
  gpio_reg_e    reg_sel;
  logic         unused_bits;

  // An access is accepted on the cycle stb is seen with ack low; ack then blocks a second one.
  assign access    = wb_stb_i & ~wb_ack_o;
  assign wr        = access & wb_we_i;
  assign reg_sel   = gpio_reg_e'(wb_adr_i);
  assign lane_full = lane_mask(wb_sel_i);
  assign wmask     = lane_full[N-1:0];
  assign wdat      = wb_dat_i[N-1:0] & wmask;
  assign ip_clr    = (wr && reg_sel == GPIO_REG_IP) ? wdat : '0;
  assign irq_o     = |ip_q;

  // Bus bits beyond the pin count have no storage; collect them into one sink signal.
  assign unused_bits = ^{wb_dat_i, lane_full};

  gpio_irq_sync #(.N(N), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .pad       (pad_in),
    .s         (s),
    .rise      (rise),
    .fall      (fall)
  );

  for (genvar i = 0; i < N; i++) begin : g_pad
    IOBuf u_iobuf (
      .bit_i  (out_q[i]),
      .oe_i   (dir_q[i]),
      .bit_o  (pad_in[i]),
      .pad_io (gpio_io[i])
    );
  end

  // Read multiplexer; SET/CLR/TGL all read back the output latch.
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      GPIO_REG_DAT: rd_val = s;
      GPIO_REG_DIR: rd_val = dir_q;
      GPIO_REG_SET,
      GPIO_REG_CLR,
      GPIO_REG_TGL: rd_val = out_q;
      GPIO_REG_RIE: rd_val = rie_q;
      GPIO_REG_FIE: rd_val = fie_q;
      GPIO_REG_IP:  rd_val = ip_q;
      default:      rd_val = '0;
    endcase
  end

  // Bus handshake: ack for one cycle per access, read data captured on the same edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= access;
      if (access) wb_dat_o <= 32'(rd_val);
    end
  end

  // Register file writes, honouring byte lanes through wmask/wdat.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      out_q <= '0;
      dir_q <= '0;
      rie_q <= '0;
      fie_q <= '0;
    end else if (wr) begin
      case (reg_sel)
        GPIO_REG_DAT: out_q <= (out_q & ~wmask) | wdat;
        GPIO_REG_DIR: dir_q <= (dir_q & ~wmask) | wdat;
        GPIO_REG_SET: out_q <= out_q | wdat;
        GPIO_REG_CLR: out_q <= out_q & ~wdat;
        GPIO_REG_TGL: out_q <= out_q ^ wdat;
        GPIO_REG_RIE: rie_q <= (rie_q & ~wmask) | wdat;
        GPIO_REG_FIE: fie_q <= (fie_q & ~wmask) | wdat;
        default: ;
      endcase
    end
  end

  // Sticky pending bits: a new enabled edge beats a simultaneous write-1-to-clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) ip_q <= '0;
    else            ip_q <= (ip_q & ~ip_clr) | (rise & rie_q) | (fall & fie_q);
  end

endmodule

// File: tb/tb_gpio_irq.sv
module tb_gpio_irq;
  localparam int N  = 16;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        ack;
  logic        irq;
  wire [N-1:0] gpio;
  logic [N-1:0] tb_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_irq #(.N(N), .SYNC_STAGES(SS)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_i),
    .wb_dat_o  (dat_o),
    .wb_we_i   (we),
    .wb_sel_i  (sel),
    .wb_stb_i  (stb),
    .wb_ack_o  (ack),
    .gpio_io   (gpio),
    .irq_o     (irq)
  );

  // ---------------- reference model ----------------
  logic [N-1:0] m_out, m_dir, m_rie, m_fie, m_ip;
  logic         m_ack;
  logic [31:0]  m_exp_rd;
  logic [N-1:0] pad_hist [0:SS];   // pad_hist[k] = pad value sampled k+1 edges ago
  logic [N-1:0] m_pad, m_s, m_p, m_rise, m_fall, m_lanes, m_wd, m_clr;
  logic         m_acc;

  // The bench drives every pin the DUT is not driving.
  for (genvar i = 0; i < N; i++) begin : g_drv
    assign gpio[i] = m_dir[i] ? 1'bz : tb_val[i];
  end

  assign m_pad   = (m_out & m_dir) | (tb_val & ~m_dir);
  assign m_s     = pad_hist[SS-1];
  assign m_p     = pad_hist[SS];
  assign m_rise  = m_s & ~m_p;
  assign m_fall  = ~m_s & m_p;
  assign m_lanes = {{8{sel[1]}}, {8{sel[0]}}};
  assign m_wd    = dat_i[N-1:0] & m_lanes;
  assign m_acc   = stb && !m_ack;
  assign m_clr   = (m_acc && we && adr == 3'd7) ? m_wd : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= '0; m_dir <= '0; m_rie <= '0; m_fie <= '0; m_ip <= '0;
      m_ack <= 1'b0; m_exp_rd <= '0;
      for (int j = 0; j <= SS; j++) pad_hist[j] <= '0;
    end else begin
      pad_hist[0] <= m_pad;
      for (int j = 1; j <= SS; j++) pad_hist[j] <= pad_hist[j-1];
      m_ack <= m_acc;
      m_ip  <= (m_ip & ~m_clr) | (m_rise & m_rie) | (m_fall & m_fie);
      if (m_acc) begin
        case (adr)
          3'd0:              m_exp_rd <= {16'h0, m_s};
          3'd1:              m_exp_rd <= {16'h0, m_dir};
          3'd2, 3'd3, 3'd4:  m_exp_rd <= {16'h0, m_out};
          3'd5:              m_exp_rd <= {16'h0, m_rie};
          3'd6:              m_exp_rd <= {16'h0, m_fie};
          default:           m_exp_rd <= {16'h0, m_ip};
        endcase
        if (we) begin
          case (adr)
            3'd0: m_out <= (m_out & ~m_lanes) | m_wd;
            3'd1: m_dir <= (m_dir & ~m_lanes) | m_wd;
            3'd2: m_out <= m_out | m_wd;
            3'd3: m_out <= m_out & ~m_wd;
            3'd4: m_out <= m_out ^ m_wd;
            3'd5: m_rie <= (m_rie & ~m_lanes) | m_wd;
            3'd6: m_fie <= (m_fie & ~m_lanes) | m_wd;
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tick1();
    @(posedge clk); #1;
    chk("irq_vs_model", 32'(irq), 32'(|m_ip));
    chk("pins_vs_model", 32'(gpio & m_dir), 32'(m_out & m_dir));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick1();
  endtask

  task automatic bus(input logic [2:0] a, input logic w, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] r);
    adr = a; we = w; sel = s; dat_i = d; stb = 1'b1;
    chk("ack_before_edge", 32'(ack), 32'd0);
    tick1();
    chk("ack_one_cycle", 32'(ack), 32'd1);
    r = dat_o;
    stb = 1'b0; we = 1'b0;
    tick1();
    chk("ack_drop", 32'(ack), 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, 1'b1, 4'hF, d, r);
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 1'b0, 4'hF, 32'h0, r);
    chk(nm, r, exp);
  endtask

  typedef struct {
    logic [2:0]  adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [2:0] a, input logic w, input logic [3:0] s,
                     input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.adr = a; v.we = w; v.sel = s; v.dat = d; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 3'd0; dat_i = '0;
    tb_val = 16'h5AC3;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat_o", dat_o, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    ticks(4);

    // directed table: all pins inputs after reset, so DAT shows what the bench drives
    add(3'd0, 0, 4'hF, 32'h0, 32'h0000_5AC3);
    for (int a = 1; a < 8; a++) add(3'(a), 0, 4'hF, 32'h0, 32'h0);
    add(3'd1, 1, 4'hF, 32'h0000_00FF, 32'h0);
    add(3'd0, 1, 4'hF, 32'h0000_00A5, 32'h0);
    add(3'd2, 1, 4'hF, 32'h0000_0002, 32'h0);
    add(3'd3, 1, 4'hF, 32'h0000_0001, 32'h0);
    add(3'd4, 1, 4'hF, 32'h0000_00F0, 32'h0);
    add(3'd2, 0, 4'hF, 32'h0, 32'h0000_0056);
    add(3'd3, 0, 4'hF, 32'h0, 32'h0000_0056);
    add(3'd4, 0, 4'hF, 32'h0, 32'h0000_0056);
    add(3'd0, 0, 4'hF, 32'h0, 32'h0000_5A56);
    add(3'd1, 0, 4'hF, 32'h0, 32'h0000_00FF);
    add(3'd1, 1, 4'hF, 32'h0, 32'h0);
    add(3'd1, 1, 4'b0010, 32'hFFFF_FFFF, 32'h0);
    add(3'd1, 0, 4'hF, 32'h0, 32'h0000_FF00);
    add(3'd0, 1, 4'b1100, 32'hFFFF_FFFF, 32'h0);
    add(3'd2, 0, 4'hF, 32'h0, 32'h0000_0056);
    add(3'd0, 0, 4'hF, 32'h0, 32'h0000_00C3);
    add(3'd5, 1, 4'hF, 32'hFFFF_FFFF, 32'h0);
    add(3'd5, 0, 4'hF, 32'h0, 32'h0000_FFFF);
    add(3'd5, 1, 4'hF, 32'h0, 32'h0);
    for (int k = 0; k < tbl.size(); k++) begin
      bus(tbl[k].adr, tbl[k].we, tbl[k].sel, tbl[k].dat, r);
      if (!tbl[k].we) chk($sformatf("tbl%0d_adr%0d", k, tbl[k].adr), r, tbl[k].exp);
      if (k == 13) chk("pins_7_0", 32'(gpio[7:0]), 32'h56);
    end

    // edge detection and W1C
    wr(3'd1, 32'h0);
    tb_val = 16'h0002;
    ticks(4);
    wr(3'd5, 32'h1);
    wr(3'd6, 32'h2);
    wr(3'd7, 32'hFFFF);
    rd_chk("ip_clear", 3'd7, 32'h0);
    tb_val = 16'h0001;
    tick1();
    tick1();
    chk("irq_t2", 32'(irq), 32'd0);
    tick1();
    chk("irq_t3", 32'(irq), 32'd1);
    rd_chk("ip_both", 3'd7, 32'h3);
    wr(3'd7, 32'h1);
    rd_chk("ip_after_w1c0", 3'd7, 32'h2);
    chk("irq_still", 32'(irq), 32'd1);
    wr(3'd7, 32'h2);
    chk("irq_clear", 32'(irq), 32'd0);

    // disabled falling edge on pin0 is lost
    tb_val = 16'h0000;
    ticks(4);
    rd_chk("ip_lost_fall", 3'd7, 32'h0);
    tb_val = 16'h0001;
    ticks(4);
    rd_chk("ip_rise0", 3'd7, 32'h1);
    wr(3'd7, 32'h1);
    rd_chk("ip_cleared0", 3'd7, 32'h0);

    // rising edge lands on the same edge as the W1C
    tb_val = 16'h0000;
    ticks(4);
    tb_val = 16'h0001;
    ticks(2);
    wr(3'd7, 32'h1);
    rd_chk("ip_set_wins", 3'd7, 32'h1);
    chk("irq_set_wins", 32'(irq), 32'd1);
    wr(3'd7, 32'hFFFF);

    // reset during accesses
    tb_val = 16'h0002;
    ticks(4);
    wr(3'd7, 32'hFFFF);
    tb_val = 16'h0001;
    ticks(4);
    chk("irq_pre_reset", 32'(irq), 32'd1);
    adr = 3'd7; we = 1'b0; sel = 4'hF; stb = 1'b1;
    @(posedge clk); #1;
    chk("ack_pre_reset", 32'(ack), 32'd1);
    chk("dat_pre_reset", dat_o, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("ack_async_rst", 32'(ack), 32'd0);
    chk("irq_async_rst", 32'(irq), 32'd0);
    chk("dat_async_rst", dat_o, 32'd0);
    stb = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    tick1();
    adr = 3'd1; we = 1'b1; sel = 4'hF; dat_i = 32'hFFFF; stb = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("ack_rst_wr", 32'(ack), 32'd0);
    stb = 1'b0; we = 1'b0;
    #2 rst_n = 1'b1;
    tick1();
    rd_chk("dir_lost_write", 3'd1, 32'h0);
    rd_chk("ip_after_rst", 3'd7, 32'h0);

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        tb_val = tb_val ^ 16'($urandom);
        tick1();
      end else begin
        bus(3'($urandom_range(0, 7)), 1'($urandom), 4'($urandom), $urandom, r);
        chk("rand_rdata", r, m_exp_rd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
